// File: rtl/receive_queue_arbiter.sv
// Receive queue write-port arbiter: burst-limited round-robin across request
// decoders, feeding a one-entry registered output stage.
package receive_queue_arbiter_pkg;
    typedef logic [15:0] receive_queue_data_t;
endpackage

module receive_queue_arbiter
    import receive_queue_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int MAX_BURST   = 2,
    localparam int IDW        = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1,
    localparam int BW         = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_SOURCES-1:0]    src_valid,
    output logic [NUM_SOURCES-1:0]    src_ready,
    input  receive_queue_data_t       src_data [NUM_SOURCES],
    output logic                      arbiter_receive_queue_valid,
    input  logic                      receive_queue_arbiter_ready,
    output receive_queue_data_t       arbiter_receive_queue_data,
    output logic [IDW-1:0]            grant_id
);

    logic [IDW-1:0]         owner_r;
    logic [BW-1:0]          burst_r;
    logic                   out_valid_r;
    receive_queue_data_t    out_data_r;
    logic [IDW-1:0]         grant_id_r;

    logic                   load_s;
    logic [NUM_SOURCES-1:0] owner_mask_s;
    logic                   others_s;
    logic                   keep_s;
    logic [IDW-1:0]         sel_s;
    logic                   found_s;
    logic [IDW:0]           cand_s;
    logic [NUM_SOURCES-1:0] ready_s;
    logic                   xfer_s;

    assign load_s       = ~out_valid_r | receive_queue_arbiter_ready;
    assign owner_mask_s = NUM_SOURCES'(1) << owner_r;
    assign others_s     = |(src_valid & ~owner_mask_s);
    assign keep_s       = src_valid[owner_r] & ((burst_r < BW'(MAX_BURST)) | ~others_s);

    // Source selection: stay with the owner or scan forward from owner+1 with wrap.
    always_comb begin
        sel_s   = owner_r;
        found_s = 1'b0;
        cand_s  = '0;
        if (keep_s) begin
            sel_s = owner_r;
        end else begin
            for (int i = 1; i < NUM_SOURCES; i++) begin
                cand_s = {1'b0, owner_r} + (IDW+1)'(i);
                if (cand_s >= (IDW+1)'(NUM_SOURCES)) begin
                    cand_s = cand_s - (IDW+1)'(NUM_SOURCES);
                end else begin
                    cand_s = cand_s;
                end
                if (!found_s && src_valid[cand_s[IDW-1:0]]) begin
                    sel_s   = cand_s[IDW-1:0];
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // One-hot ready to the selected source; suppressed in reset, flush and stall.
    always_comb begin
        ready_s = '0;
        if (rst_n && load_s && (|src_valid) && !flush) begin
            ready_s[sel_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign xfer_s    = |(src_valid & ready_s);
    assign src_ready = ready_s;

    // Output stage and round-robin ownership state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            grant_id_r  <= '0;
            owner_r     <= '0;
            burst_r     <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            owner_r     <= '0;
            burst_r     <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= src_data[sel_s];
            grant_id_r  <= sel_s;
            if (sel_s == owner_r) begin
                if (burst_r < BW'(MAX_BURST)) begin
                    burst_r <= burst_r + BW'(1);
                end else begin
                    burst_r <= BW'(MAX_BURST);
                end
            end else begin
                owner_r <= sel_s;
                burst_r <= BW'(1);
            end
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign arbiter_receive_queue_valid = out_valid_r;
    assign arbiter_receive_queue_data  = out_data_r;
    assign grant_id                    = grant_id_r;

endmodule
